// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA timing mode descriptors and the default mode table
package vga_pkg;

  typedef struct packed {
    logic [31:0] pclk_khz;
    logic [15:0] h_visible;
    logic [15:0] h_sync_start;
    logic [15:0] h_sync_end;
    logic [15:0] h_total;
    logic [15:0] v_visible;
    logic [15:0] v_sync_start;
    logic [15:0] v_sync_end;
    logic [15:0] v_total;
    logic        h_sync_active_low;
    logic        v_sync_active_low;
  } vga_params_t;

  // Build a mode from the usual visible/front-porch/sync/back-porch figures.
  function automatic vga_params_t vga_make_mode(
    input int hv, input int hf, input int hs, input int hb,
    input int vv, input int vf, input int vs, input int vb,
    input bit hal, input bit val, input int khz
  );
    vga_params_t p;
    p.pclk_khz          = 32'(khz);
    p.h_visible         = 16'(hv);
    p.h_sync_start      = 16'(hv + hf);
    p.h_sync_end        = 16'(hv + hf + hs);
    p.h_total           = 16'(hv + hf + hs + hb);
    p.v_visible         = 16'(vv);
    p.v_sync_start      = 16'(vv + vf);
    p.v_sync_end        = 16'(vv + vf + vs);
    p.v_total           = 16'(vv + vf + vs + vb);
    p.h_sync_active_low = hal;
    p.v_sync_active_low = val;
    return p;
  endfunction

  localparam vga_params_t VGA_640x480_60 =
    vga_make_mode(640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1, 25175);
  localparam vga_params_t VGA_800x600_60 =
    vga_make_mode(800, 40, 128, 88, 600, 1, 4, 23, 1'b0, 1'b0, 40000);

  typedef vga_params_t vga_mode_table_t [2];

  localparam vga_mode_table_t VGA_MODE_TABLE = '{VGA_640x480_60, VGA_800x600_60};

endpackage

// File: rtl/vga_sync_pipe.sv
// rtl/vga_sync_pipe.sv - fixed-depth output delay line with per-bit reset value
module vga_sync_pipe #(
  parameter int           W       = 1,
  parameter int           DEPTH   = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("vga_sync_pipe: DEPTH must be in 1..4");
  end

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - multi-mode VGA sync/DE generator with frame-aligned mode switching
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int          NUM_MODES         = 2,
  parameter vga_params_t MODES [NUM_MODES] = VGA_MODE_TABLE,
  parameter int          PIPE_STAGES       = 1,
  parameter int          CTR_W             = 11,
  localparam int         SEL_W             = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pix_en,
  input  logic             run,
  input  logic [SEL_W-1:0] mode_sel,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CTR_W-1:0] x,
  output logic [CTR_W-1:0] y,
  output logic             frame_start,
  output logic             line_start,
  output logic [SEL_W-1:0] mode_active,
  output logic             mode_pending
);

  localparam int CMP_W = CTR_W + 1;
  localparam int PW    = 5 + 2 * CTR_W + SEL_W + 1;

  for (genvar i = 0; i < NUM_MODES; i++) begin : g_mode_chk
    if (int'(MODES[i].h_total) > (1 << CTR_W) || int'(MODES[i].v_total) > (1 << CTR_W)) begin : g_too_big
      $error("vga_timing_gen: mode total exceeds counter range");
    end
  end

  logic [CTR_W-1:0] h, v;
  logic [SEL_W-1:0] act_q, pend_sel, next_act;
  logic             pend_q;

  logic [CMP_W-1:0] h_vis, h_ss, h_se, h_tot, v_vis, v_ss, v_se, v_tot;
  logic             h_al, v_al;

  always_comb begin
    h_vis = '0; h_ss = '0; h_se = '0; h_tot = '0;
    v_vis = '0; v_ss = '0; v_se = '0; v_tot = '0;
    h_al  = 1'b0; v_al = 1'b0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (act_q == SEL_W'(i)) begin
        h_vis = CMP_W'(MODES[i].h_visible);
        h_ss  = CMP_W'(MODES[i].h_sync_start);
        h_se  = CMP_W'(MODES[i].h_sync_end);
        h_tot = CMP_W'(MODES[i].h_total);
        v_vis = CMP_W'(MODES[i].v_visible);
        v_ss  = CMP_W'(MODES[i].v_sync_start);
        v_se  = CMP_W'(MODES[i].v_sync_end);
        v_tot = CMP_W'(MODES[i].v_total);
        h_al  = MODES[i].h_sync_active_low;
        v_al  = MODES[i].v_sync_active_low;
      end
    end
  end

  logic [CMP_W-1:0] hx, vx;
  logic             step, h_last, v_last, adopt, sel_valid;

  assign hx        = {1'b0, h};
  assign vx        = {1'b0, v};
  assign step      = run && pix_en;
  assign h_last    = (hx == h_tot - CMP_W'(1));
  assign v_last    = (vx == v_tot - CMP_W'(1));
  // Switch only on the frame wrap so a mode never produces a torn frame; idle switches at once.
  assign adopt     = pend_q && (!run || (step && h_last && v_last));
  assign sel_valid = int'(mode_sel) < NUM_MODES;
  assign next_act  = adopt ? pend_sel : act_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h        <= '0;
      v        <= '0;
      act_q    <= '0;
      pend_q   <= 1'b0;
      pend_sel <= '0;
    end else begin
      if (!run) begin
        h <= '0;
        v <= '0;
      end else if (pix_en) begin
        if (h_last) begin
          h <= '0;
          v <= v_last ? '0 : v + CTR_W'(1);
        end else begin
          h <= h + CTR_W'(1);
        end
      end
      act_q <= next_act;
      if (sel_valid) begin
        pend_sel <= mode_sel;
        pend_q   <= (mode_sel != next_act);
      end else if (adopt) begin
        pend_q <= 1'b0;
      end
    end
  end

  logic             raw_hs, raw_vs, raw_de, raw_ls, raw_fs;
  logic [CTR_W-1:0] raw_x, raw_y;

  assign raw_hs = (run && hx >= h_ss && hx < h_se) ? ~h_al : h_al;
  assign raw_vs = (run && vx >= v_ss && vx < v_se) ? ~v_al : v_al;
  assign raw_de = run && (hx < h_vis) && (vx < v_vis);
  assign raw_x  = raw_de ? h : '0;
  assign raw_y  = raw_de ? v : '0;
  assign raw_ls = step && (h == '0);
  assign raw_fs = raw_ls && (v == '0);

  localparam logic [PW-1:0] RST_VAL = {MODES[0].h_sync_active_low,
                                       MODES[0].v_sync_active_low, {(PW-2){1'b0}}};

  logic [PW-1:0] pipe_q;

  vga_sync_pipe #(
    .W       (PW),
    .DEPTH   (PIPE_STAGES),
    .RST_VAL (RST_VAL)
  ) u_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({raw_hs, raw_vs, raw_de, raw_ls, raw_fs, raw_x, raw_y, act_q, pend_q}),
    .q       (pipe_q)
  );

  assign {hsync, vsync, de, line_start, frame_start, x, y, mode_active, mode_pending} = pipe_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_MODES, 2, number of timing modes in the table.
- MODES, vga_pkg::VGA_MODE_TABLE, array [NUM_MODES] of vga_params_t.
- PIPE_STAGES, 1, output register stages (range 1..4).
- CTR_W, 11, width of x/y and internal counters.
REQ-002 The block SHALL have these ports (name, direction, width, meaning); clocking is one clock, and reset is asynchronous and active-low:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- pix_en, in, 1, pixel-rate clock enable.
- run, in, 1, timing generation enable.
- mode_sel, in, $clog2(NUM_MODES), requested mode.
- hsync, out, 1, horizontal sync with the mode's polarity applied.
- vsync, out, 1, vertical sync with the mode's polarity applied.
- de, out, 1, visible-area data enable.
- x, out, CTR_W, pixel column.
- y, out, CTR_W, pixel row.
- frame_start, out, 1, pulse at pixel (0,0).
- line_start, out, 1, pulse at h=0.
- mode_active, out, $clog2(NUM_MODES), mode currently driving timing.
- mode_pending, out, 1, mode change is queued.

Function
REQ-003 Counters h and v SHALL update only on clk edges where pix_en=1 and run=1.
REQ-004 h SHALL count 0..h_total-1 of the active mode; on wrap it SHALL return to 0 and increment v.
REQ-005 v SHALL wrap from v_total-1 to 0 on the same pix_en cycle in which h wraps.
REQ-006 Raw hsync SHALL be asserted for h in [h_sync_start, h_sync_end) and SHALL drive level (h_sync_active_low ? 0 : 1) when asserted, else the inverse; vsync SHALL follow the same rule on v.
REQ-007 de SHALL be 1 iff h<h_visible and v<v_visible.
REQ-008 x,y SHALL equal h,v when de=1, else 0.
REQ-009 line_start SHALL be 1 for exactly one pix_en-qualified cycle when h=0; frame_start SHALL additionally require v=0.
REQ-010 All outputs SHALL be delayed by exactly PIPE_STAGES clk cycles from the counter state, with identical delay for every output.
REQ-011 Each pipeline stage SHALL advance every clk cycle, independent of pix_en.
REQ-012 A mode_sel that differs from mode_active and is < NUM_MODES SHALL set mode_pending on the next clk.
REQ-013 An out-of-range mode_sel SHALL be ignored.
REQ-014 A pending mode SHALL be adopted on the frame-wrap cycle (h=h_total-1, v=v_total-1, pix_en=1); h and v SHALL restart at 0 under the new mode and mode_pending SHALL clear.
REQ-015 If mode_sel changes again while a change is pending, the latest valid value SHALL be adopted at the wrap; if it returns to mode_active, mode_pending SHALL clear without a switch.
REQ-016 While run=0, h and v SHALL be held at 0, de=0, x=y=0, start pulses SHALL be 0, and syncs SHALL be at the inactive level.
REQ-017 While run=0, a pending mode SHALL be adopted immediately.
REQ-018 On run 0->1, the first pix_en cycle SHALL produce frame_start.
REQ-019 pix_en held at 0 SHALL freeze all counters; held at 1 (pix_en=clk) SHALL be legal.

Reset
REQ-020 On reset_n=0, asynchronously: h=v=0, mode_active=0, mode_pending=0, de=0, x=y=0, start pulses=0, every pipeline stage cleared.
REQ-021 On reset_n=0, syncs SHALL be at mode 0's inactive level.
REQ-022 Reset asserted mid-frame SHALL abandon the frame and any pending mode.
REQ-023 Reset release SHALL take effect synchronously to clk.

Structure
REQ-024 vga_pkg SHALL gain:
- VGA_800x600_60 (40 MHz; H 800/40/128/88; V 600/1/4/23; positive polarity).
- typedef vga_mode_table_t.
- VGA_MODE_TABLE = {VGA_640x480_60, VGA_800x600_60}.
REQ-025 Delay stages SHALL be one sub-module, vga_sync_pipe (parametrised depth, reset-cleared, per-bit reset value).
REQ-026 Elaboration SHALL fail if any mode's h_total or v_total exceeds 2**CTR_W.

Verification
REQ-027 Reset release, mode 0, pix_en=1, run=1 -> hsync low exactly h=656..751; vsync low exactly lines 490..491; frame_start every 420000 cycles.
REQ-028 Same setup -> de high 640 cycles per line on lines 0..479; x=639,y=479 on last visible pixel, x=y=0 during blanking.
REQ-029 mode_sel 0->1 at line 100 -> mode_pending=1 until frame wrap; next frame h_total=1056, v_total=628, hsync high h=840..967, vsync high lines 601..604.
REQ-030 pix_en one-in-four, PIPE_STAGES=3 -> frame length 4*420000 clk; all outputs lag counters by 3 clk; line_start one clk wide.
REQ-031 Deassert run at v=200 -> syncs inactive and de=0 after 1 clk; reassert run -> frame_start on first pix_en.
REQ-032 Assert reset_n=0 mid-frame with a change pending -> outputs cleared immediately; mode_active=0; mode_pending=0.
